bounding_box_top: RTL and testbench



---
 rtl/bounding_box_top.sv | 107 ++++++++++
 tb/tb_bounding_box_top.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/bounding_box_top.sv
// Bounding-box extractor: scans a 100x100 frame memory once after reset and
// records the min/max column and row of all non-zero pixels, then raises done.
module bounding_box_top (
  input logic       CLOCK_50,
  input logic [3:0] KEY
);

  typedef enum logic [1:0] {
    S_SCAN  = 2'b00,
    S_FLUSH = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  logic [7:0]  ram [0:9999];

  state_e      state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic [6:0]  x_q, x_d, y_q, y_d;
  logic [6:0]  xp_q, yp_q;
  logic        pv_q;
  logic [7:0]  rdata_q;

  logic        done, done_d;
  logic [6:0]  xMin, yMin, xMax, yMax;
  logic [6:0]  xMin_d, yMin_d, xMax_d, yMax_d;
  logic        fg_s;
  logic        unused_key_s;

  assign unused_key_s = &{1'b0, KEY[2:0]};

  // Scan sequencing: one address per cycle, x/y track the address without a multiplier.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      S_SCAN: begin
        if (addr_q == 14'd9999) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_SCAN;
        end
        addr_d = addr_q + 14'd1;
        if (x_q == 7'd99) begin
          x_d = 7'd0;
          y_d = y_q + 7'd1;
        end else begin
          x_d = x_q + 7'd1;
          y_d = y_q;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_SCAN;
    endcase
  end

  // Extent update: all four comparisons in parallel on the returned pixel.
  always_comb begin
    fg_s   = pv_q && (rdata_q != 8'd0) && !done;
    done_d = (state_q == S_DONE) ? 1'b1 : done;
    if (fg_s && (xp_q < xMin)) xMin_d = xp_q; else xMin_d = xMin;
    if (fg_s && (xp_q > xMax)) xMax_d = xp_q; else xMax_d = xMax;
    if (fg_s && (yp_q < yMin)) yMin_d = yp_q; else yMin_d = yMin;
    if (fg_s && (yp_q > yMax)) yMax_d = yp_q; else yMax_d = yMax;
  end

  // State, counters, pixel-coordinate pipeline and result registers.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY[3]) begin
      state_q <= S_SCAN;
      addr_q  <= 14'd0;
      x_q     <= 7'd0;
      y_q     <= 7'd0;
      xp_q    <= 7'd0;
      yp_q    <= 7'd0;
      pv_q    <= 1'b0;
      done    <= 1'b0;
      xMin    <= 7'd99;
      yMin    <= 7'd99;
      xMax    <= 7'd0;
      yMax    <= 7'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xp_q    <= x_q;
      yp_q    <= y_q;
      pv_q    <= (state_q == S_SCAN);
      done    <= done_d;
      xMin    <= xMin_d;
      yMin    <= yMin_d;
      xMax    <= xMax_d;
      yMax    <= yMax_d;
    end
  end

  // Synchronous frame-memory read; only in-range addresses are read.
  always_ff @(posedge CLOCK_50) begin
    if (state_q == S_SCAN) begin
      rdata_q <= ram[addr_q];
    end
  end

endmodule

// File: tb/tb_bounding_box_top.sv
// Directed bench: loads frame images hierarchically, predicts bounding boxes
// through a scoreboard queue and checks done timing and reset behaviour.
module tb_bounding_box_top;

  logic       clk = 1'b0;
  logic [3:0] key = 4'b0111;

  always #5 clk = ~clk;

  bounding_box_top dut (
    .CLOCK_50(clk),
    .KEY     (key)
  );

  typedef struct {
    string tag;
    int    x0, y0, x1, y1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rst_done"}, {31'd0, dut.done}, 32'd0);
    check({tag, "_rst_xmin"}, {25'd0, dut.xMin}, 32'd99);
    check({tag, "_rst_ymin"}, {25'd0, dut.yMin}, 32'd99);
    check({tag, "_rst_xmax"}, {25'd0, dut.xMax}, 32'd0);
    check({tag, "_rst_ymax"}, {25'd0, dut.yMax}, 32'd0);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 10000; i++) dut.ram[i] = 8'h00;
  endtask

  task automatic set_px(input int x, input int y);
    dut.ram[y * 100 + x] = 8'($urandom_range(1, 255));
  endtask

  task automatic push_exp(input string tag, input int x0, input int y0, input int x1, input int y1);
    exp_t e;
    e.tag = tag; e.x0 = x0; e.y0 = y0; e.x1 = x1; e.y1 = y1;
    sb.push_back(e);
  endtask

  // One-cycle reset pulse; leaves KEY[3] high just before edge 1.
  task automatic start_scan(input string tag);
    @(posedge clk); #1 key[3] = 1'b0;
    @(posedge clk); #1;
    check_reset(tag);
    key[3] = 1'b1;
  endtask

  // Counts edges from release until done, then pops and compares the result.
  task automatic wait_done();
    int   n;
    exp_t e;
    n = 0;
    while (n < 12000) begin
      @(posedge clk); n++; #1;
      if (dut.done) break;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_done_edge"}, n, 10002);
      check({e.tag, "_xmin"}, {25'd0, dut.xMin}, e.x0);
      check({e.tag, "_ymin"}, {25'd0, dut.yMin}, e.y0);
      check({e.tag, "_xmax"}, {25'd0, dut.xMax}, e.x1);
      check({e.tag, "_ymax"}, {25'd0, dut.yMax}, e.y1);
    end
  endtask

  initial begin
    // Square outline, columns 28..79, rows 29..65.
    clear_img();
    for (int x = 28; x <= 79; x++) begin set_px(x, 29); set_px(x, 65); end
    for (int y = 29; y <= 65; y++) begin set_px(28, y); set_px(79, y); end

    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_reset("hold_low");
    end

    // Scan the square, abort with reset at edge 5000, then finish.
    push_exp("square", 28, 29, 79, 65);
    key[3] = 1'b1;
    for (int n = 1; n < 5000; n++) @(posedge clk);
    #1 check("mid_done_low", {31'd0, dut.done}, 32'd0);
    key[3] = 1'b0;
    @(posedge clk); #1;
    check_reset("abort");
    key[3] = 1'b1;
    wait_done();
    @(posedge clk); #1;
    check("square_done_held", {31'd0, dut.done}, 32'd1);

    clear_img();
    for (int y = 34; y <= 78; y++)
      for (int x = 28; x <= 28 + ((y - 34) * 41) / 44; x++) set_px(x, y);
    push_exp("triangle", 28, 34, 69, 78);
    start_scan("triangle");
    wait_done();

    clear_img();
    set_px(27, 52); set_px(81, 53); set_px(54, 27); set_px(54, 78);
    set_px(35, 35); set_px(73, 70);
    push_exp("circle", 27, 27, 81, 78);
    start_scan("circle");
    wait_done();

    clear_img();
    set_px(4, 40); set_px(84, 20); set_px(30, 16); set_px(60, 77);
    set_px(50, 50); set_px(10, 60);
    push_exp("irregular", 4, 16, 84, 77);
    start_scan("irregular");
    wait_done();

    clear_img();
    set_px(99, 99);
    push_exp("px99", 99, 99, 99, 99);
    start_scan("px99");
    wait_done();

    clear_img();
    set_px(0, 0);
    push_exp("px0", 0, 0, 0, 0);
    start_scan("px0");
    wait_done();

    clear_img();
    push_exp("empty", 99, 99, 0, 0);
    start_scan("empty");
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
